sysio_axi_arb: RTL and testbench

//  2-master -> 1-slave AXI4-Lite arbiter in front of the sysio peripheral bus.
//  M0 = core data port, M1 = debug/DMA master. Round-robin write and read grants.

---
 rtl/sysio_axi_arb_pkg.sv | 21 ++
 rtl/sysio_axi_arb_rr_arb2.sv | 25 ++
 rtl/sysio_axi_arb.sv | 126 ++++++++++++
 tb/tb_sysio_axi_arb.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysio_axi_arb_pkg.sv
// Shared constants for the sysio AXI4-Lite 2:1 arbiter: read FSM encoding,
// master indices and default bus widths.
package sysio_axi_arb_pkg;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_BUSY = 1'b1
    } rd_state_e;

    localparam logic M_CORE = 1'b0;
    localparam logic M_DBG  = 1'b1;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    // One-hot grant to master index; an empty grant reads as M_CORE.
    function automatic logic gnt_idx(input logic [1:0] gnt);
        return gnt[1] ? M_DBG : M_CORE;
    endfunction

endpackage

// File: rtl/sysio_axi_arb_rr_arb2.sv
// Two-way pick: a lone requester always wins; on a tie the master that did not
// win last time goes, unless fix_prio pins the tie to the core port.
module rr_arb2
    import sysio_axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fix_prio,
    output logic [1:0] gnt
);

    logic tie_win;

    always_comb begin
        tie_win = (fix_prio || (last == M_DBG)) ? M_CORE : M_DBG;
        gnt     = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (tie_win == M_DBG) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/sysio_axi_arb.sv
// 2-master to 1-slave AXI4-Lite arbiter for the sysio bus. Writes are granted
// combinationally (AW+W together, no B); reads allow one transaction in flight.
module sysio_axi_arb
    import sysio_axi_arb_pkg::*;
#(
    parameter int AW       = MEM_ADDR_W,
    parameter int DW       = MEM_DATA_W,
    parameter bit FIX_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] m0_awaddr,
    input  logic          m0_awvalid,
    output logic          m0_awready,
    input  logic [DW-1:0] m0_wdata,
    input  logic [3:0]    m0_wstrb,
    input  logic          m0_wvalid,
    output logic          m0_wready,
    input  logic [AW-1:0] m0_araddr,
    input  logic          m0_arvalid,
    output logic          m0_arready,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_rvalid,
    input  logic          m0_rready,
    input  logic [AW-1:0] m1_awaddr,
    input  logic          m1_awvalid,
    output logic          m1_awready,
    input  logic [DW-1:0] m1_wdata,
    input  logic [3:0]    m1_wstrb,
    input  logic          m1_wvalid,
    output logic          m1_wready,
    input  logic [AW-1:0] m1_araddr,
    input  logic          m1_arvalid,
    output logic          m1_arready,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_rvalid,
    input  logic          m1_rready,
    output logic [AW-1:0] s_awaddr,
    output logic          s_awvalid,
    input  logic          s_awready,
    output logic [DW-1:0] s_wdata,
    output logic [3:0]    s_wstrb,
    output logic          s_wvalid,
    input  logic          s_wready,
    output logic [AW-1:0] s_araddr,
    output logic          s_arvalid,
    input  logic          s_arready,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_rvalid,
    output logic          s_rready
);

    logic [1:0] wr_req, wr_gnt, rd_req, rd_gnt;
    logic       wr_sel, rd_sel, rd_idle, live;
    logic       wr_last_q, wr_last_d;
    logic       rd_last_q, rd_last_d;
    logic       rd_owner_q, rd_owner_d;
    rd_state_e  rd_state_q, rd_state_d;

    // Handshake outputs are held low during reset regardless of inputs.
    assign live    = !rst;
    assign wr_req  = {m1_awvalid & m1_wvalid, m0_awvalid & m0_wvalid};
    assign rd_req  = {m1_arvalid, m0_arvalid};
    assign wr_sel  = gnt_idx(wr_gnt);
    assign rd_sel  = gnt_idx(rd_gnt);
    assign rd_idle = (rd_state_q == R_IDLE);

    rr_arb2 u_wr_arb (.req(wr_req), .last(wr_last_q), .fix_prio(FIX_PRIO), .gnt(wr_gnt));
    rr_arb2 u_rd_arb (.req(rd_req), .last(rd_last_q), .fix_prio(FIX_PRIO), .gnt(rd_gnt));

    always_comb begin
        s_awaddr   = (wr_sel == M_DBG) ? m1_awaddr : m0_awaddr;
        s_wdata    = (wr_sel == M_DBG) ? m1_wdata  : m0_wdata;
        s_wstrb    = (wr_sel == M_DBG) ? m1_wstrb  : m0_wstrb;
        s_awvalid  = live & (|wr_gnt);
        s_wvalid   = live & (|wr_gnt);
        m0_awready = live & wr_gnt[0] & s_awready;
        m0_wready  = live & wr_gnt[0] & s_wready;
        m1_awready = live & wr_gnt[1] & s_awready;
        m1_wready  = live & wr_gnt[1] & s_wready;
        wr_last_d  = wr_last_q;
        if (s_awvalid && s_awready)
            wr_last_d = wr_sel;
    end

    always_comb begin
        s_araddr   = (rd_sel == M_DBG) ? m1_araddr : m0_araddr;
        s_arvalid  = live & rd_idle & (|rd_gnt);
        m0_arready = live & rd_idle & rd_gnt[0] & s_arready;
        m1_arready = live & rd_idle & rd_gnt[1] & s_arready;
        m0_rvalid  = live & !rd_idle & (rd_owner_q == M_CORE) & s_rvalid;
        m1_rvalid  = live & !rd_idle & (rd_owner_q == M_DBG)  & s_rvalid;
        m0_rdata   = (rd_owner_q == M_CORE) ? s_rdata : '0;
        m1_rdata   = (rd_owner_q == M_DBG)  ? s_rdata : '0;
        s_rready   = live & !rd_idle & ((rd_owner_q == M_DBG) ? m1_rready : m0_rready);
        rd_state_d = rd_state_q;
        rd_owner_d = rd_owner_q;
        rd_last_d  = rd_last_q;
        case (rd_state_q)
            R_IDLE: if (s_arvalid && s_arready) begin
                rd_owner_d = rd_sel;
                rd_last_d  = rd_sel;
                rd_state_d = R_BUSY;
            end
            // Return to idle only; the next AR waits one cycle by design.
            R_BUSY: if (s_rvalid && s_rready)
                rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_last_q  <= M_DBG;
            rd_last_q  <= M_DBG;
            rd_owner_q <= M_CORE;
            rd_state_q <= R_IDLE;
        end else begin
            wr_last_q  <= wr_last_d;
            rd_last_q  <= rd_last_d;
            rd_owner_q <= rd_owner_d;
            rd_state_q <= rd_state_d;
        end
    end

endmodule

// File: tb/tb_sysio_axi_arb.sv
// Scoreboard bench for sysio_axi_arb: directed traffic from both masters, a
// simple sysio slave model, and a FIX_PRIO=1 instance sharing the same inputs.
module tb_sysio_axi_arb;

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_exp_t;

    typedef struct {
        int          m;
        logic [31:0] addr;
    } ar_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] m0_awaddr = '0, m0_wdata = '0, m0_araddr = '0;
    logic [31:0] m1_awaddr = '0, m1_wdata = '0, m1_araddr = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic m0_awvalid = 0, m0_wvalid = 0, m0_arvalid = 0, m0_rready = 1;
    logic m1_awvalid = 0, m1_wvalid = 0, m1_arvalid = 0, m1_rready = 1;
    logic s_awready = 1, s_wready = 1, s_arready = 1, s_rvalid = 0;
    logic [31:0] s_rdata = '0;

    logic m0_awready, m0_wready, m0_arready, m0_rvalid;
    logic m1_awready, m1_wready, m1_arready, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata, s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic s_awvalid, s_wvalid, s_arvalid, s_rready;

    logic f_m0_awready, f_m0_wready, f_m0_arready, f_m0_rvalid;
    logic f_m1_awready, f_m1_wready, f_m1_arready, f_m1_rvalid;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_s_awaddr, f_s_wdata, f_s_araddr;
    logic [3:0]  f_s_wstrb;
    logic f_s_awvalid, f_s_wvalid, f_s_arvalid, f_s_rready;

    sysio_axi_arb #(.AW(32), .DW(32), .FIX_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    sysio_axi_arb #(.AW(32), .DW(32), .FIX_PRIO(1'b1)) dut_fix (
        .clk(clk), .rst(rst),
        .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(f_m0_awready),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(f_m0_wready),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(f_m0_arready),
        .m0_rdata(f_m0_rdata), .m0_rvalid(f_m0_rvalid), .m0_rready(m0_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(f_m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(f_m1_wready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(f_m1_arready),
        .m1_rdata(f_m1_rdata), .m1_rvalid(f_m1_rvalid), .m1_rready(m1_rready),
        .s_awaddr(f_s_awaddr), .s_awvalid(f_s_awvalid), .s_awready(s_awready),
        .s_wdata(f_s_wdata), .s_wstrb(f_s_wstrb), .s_wvalid(f_s_wvalid), .s_wready(s_wready),
        .s_araddr(f_s_araddr), .s_arvalid(f_s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(f_s_rready)
    );

    int errors = 0, checks = 0, cyc = 0, fix_w_n = 0, fix_r_n = 0, last_r_cyc = 0;
    bit chk_gap = 0, gap_arm = 0;
    wr_exp_t     w_q[$];
    ar_exp_t     ar_q[$];
    logic [31:0] r0_q[$], r1_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] outs_main();
        return {m0_awready, m0_wready, m0_arready, m0_rvalid,
                m1_awready, m1_wready, m1_arready, m1_rvalid,
                s_awvalid, s_wvalid, s_arvalid, s_rready};
    endfunction

    // sysio model: always ready for AW/W/AR, answers a read one cycle later
    // with addr ^ DEADBEEF and holds it until taken; cleared by the shared reset.
    initial begin : slave
        logic ar_hs, r_hs;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            ar_hs = s_arvalid && s_arready;
            r_hs  = s_rvalid && s_rready;
            a     = s_araddr;
            @(posedge clk);
            #1;
            if (rst) s_rvalid = 1'b0;
            else begin
                if (r_hs) s_rvalid = 1'b0;
                if (ar_hs) begin
                    s_rvalid = 1'b1;
                    s_rdata  = a ^ 32'hDEAD_BEEF;
                end
            end
        end
    end

    initial begin : monitor
        wr_exp_t we;
        ar_exp_t ae;
        logic [31:0] rd;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (s_awvalid && s_awready && s_wvalid && s_wready) begin
                    if (w_q.size() == 0) chk("wr_unexpected", 1, 0);
                    else begin
                        we = w_q.pop_front();
                        chk("wr_master", {m1_awready & m1_wready, m0_awready & m0_wready},
                            (we.m == 1) ? 2'b10 : 2'b01);
                        chk("wr_addr", s_awaddr, we.addr);
                        chk("wr_data", {s_wstrb, s_wdata}, {we.strb, we.data});
                    end
                end
                if (s_arvalid && s_arready) begin
                    if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
                    else begin
                        ae = ar_q.pop_front();
                        chk("ar_master", {m1_arready, m0_arready}, (ae.m == 1) ? 2'b10 : 2'b01);
                        chk("ar_addr", s_araddr, ae.addr);
                    end
                    if (gap_arm && chk_gap) chk("rd_bubble", cyc - last_r_cyc, 1);
                    gap_arm = 0;
                end
                if (m0_rvalid && m0_rready) begin
                    chk("rd0_other_rvalid", m1_rvalid, 0);
                    chk("rd0_ar_in_busy", s_arvalid, 0);
                    if (r0_q.size() == 0) chk("rd0_unexpected", 1, 0);
                    else begin rd = r0_q.pop_front(); chk("rd0_data", m0_rdata, rd); end
                    last_r_cyc = cyc; gap_arm = chk_gap;
                end
                if (m1_rvalid && m1_rready) begin
                    chk("rd1_other_rvalid", m0_rvalid, 0);
                    chk("rd1_ar_in_busy", s_arvalid, 0);
                    if (r1_q.size() == 0) chk("rd1_unexpected", 1, 0);
                    else begin rd = r1_q.pop_front(); chk("rd1_data", m1_rdata, rd); end
                    last_r_cyc = cyc; gap_arm = chk_gap;
                end
                // Fixed-priority instance: any tie must go to M0.
                if (m0_awvalid && m0_wvalid && m1_awvalid && m1_wvalid && f_s_awvalid && s_awready) begin
                    chk("fix_wr_grant", {f_m1_awready, f_m1_wready, f_m0_awready, f_m0_wready, f_s_wvalid}, 5'b00111);
                    chk("fix_wr_addr", f_s_awaddr, m0_awaddr);
                    chk("fix_wr_data", {f_s_wstrb, f_s_wdata}, {m0_wstrb, m0_wdata});
                    fix_w_n++;
                end
                if (m0_arvalid && m1_arvalid && f_s_arvalid && s_arready) begin
                    chk("fix_rd_grant", {f_m1_arready, f_m0_arready}, 2'b01);
                    chk("fix_rd_addr", f_s_araddr, m0_araddr);
                    fix_r_n++;
                end
                if (f_s_rready && s_rvalid) begin
                    chk("fix_r_onehot", f_m0_rvalid ^ f_m1_rvalid, 1);
                    chk("fix_r_route", f_m0_rvalid ? f_m0_rdata : f_m1_rdata, s_rdata);
                end
            end
        end
    end

    task automatic m_write(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        bit hs;
        n = 0;
        if (m == 0) begin m0_awaddr = a; m0_wdata = d; m0_wstrb = s; m0_awvalid = 1; m0_wvalid = 1; end
        else        begin m1_awaddr = a; m1_wdata = d; m1_wstrb = s; m1_awvalid = 1; m1_wvalid = 1; end
        forever begin
            @(negedge clk);
            hs = (m == 0) ? (m0_awready & m0_wready) : (m1_awready & m1_wready);
            @(posedge clk);
            #1;
            if (hs) break;
            n++;
            if (n > 60) begin chk("wr_timeout", 0, 1); break; end
        end
        if (m == 0) begin m0_awvalid = 0; m0_wvalid = 0; end
        else        begin m1_awvalid = 0; m1_wvalid = 0; end
    endtask

    task automatic m_read(input int m, input logic [31:0] a);
        int n;
        bit hs;
        n = 0;
        if (m == 0) begin m0_araddr = a; m0_arvalid = 1; end
        else        begin m1_araddr = a; m1_arvalid = 1; end
        forever begin
            @(negedge clk);
            hs = (m == 0) ? m0_arready : m1_arready;
            @(posedge clk);
            #1;
            if (hs) break;
            n++;
            if (n > 60) begin chk("ar_timeout", 0, 1); break; end
        end
        if (m == 0) m0_arvalid = 0;
        else        m1_arvalid = 0;
    endtask

    task automatic wait_rvalid(input int m);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if ((m == 0) ? m0_rvalid : m1_rvalid) break;
            n++;
            if (n > 60) begin chk("rvalid_timeout", 0, 1); break; end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((w_q.size() + ar_q.size() + r0_q.size() + r1_q.size()) != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", w_q.size() + ar_q.size() + r0_q.size() + r1_q.size(), 0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #2 rst = 1;
        repeat (n) @(posedge clk);
        #2 rst = 0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin : stim
        int t0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs_during", outs_main(), 0);
        @(posedge clk);
        #2 rst = 0;
        @(negedge clk);
        chk("rst_outs_after", outs_main(), 0);
        @(posedge clk);
        #1;

        // 1: single M0 write, then a tie goes to M1 because M0 won last
        w_q.push_back('{0, 32'h0000_0400, 32'hA5A5_A5A5, 4'hF});
        t0 = cyc;
        m_write(0, 32'h0000_0400, 32'hA5A5_A5A5, 4'hF);
        chk("t1_latency", cyc - t0, 1);
        w_q.push_back('{1, 32'h0000_0500, 32'hCAFE_F00D, 4'hC});
        w_q.push_back('{0, 32'h0000_0408, 32'h0000_0001, 4'h1});
        t0 = cyc;
        fork
            m_write(0, 32'h0000_0408, 32'h0000_0001, 4'h1);
            m_write(1, 32'h0000_0500, 32'hCAFE_F00D, 4'hC);
        join
        chk("t1b_latency", cyc - t0, 2);

        // 2: after reset, continuous ties alternate M0,M1,M0,... one per cycle
        do_reset(2);
        w_q.push_back('{0, 32'h0000_0100, 32'h1111_1111, 4'hF});
        w_q.push_back('{1, 32'h0000_0200, 32'hAAAA_AAAA, 4'hF});
        w_q.push_back('{0, 32'h0000_0104, 32'h2222_2222, 4'hF});
        w_q.push_back('{1, 32'h0000_0204, 32'hBBBB_BBBB, 4'hF});
        w_q.push_back('{0, 32'h0000_0108, 32'h3333_3333, 4'hF});
        w_q.push_back('{1, 32'h0000_0208, 32'hCCCC_CCCC, 4'h5});
        t0 = cyc;
        fork
            begin
                m_write(0, 32'h0000_0100, 32'h1111_1111, 4'hF);
                m_write(0, 32'h0000_0104, 32'h2222_2222, 4'hF);
                m_write(0, 32'h0000_0108, 32'h3333_3333, 4'hF);
            end
            begin
                m_write(1, 32'h0000_0200, 32'hAAAA_AAAA, 4'hF);
                m_write(1, 32'h0000_0204, 32'hBBBB_BBBB, 4'hF);
                m_write(1, 32'h0000_0208, 32'hCCCC_CCCC, 4'h5);
            end
        join
        chk("t2_latency", cyc - t0, 6);

        // 3: M1 read stalled by rready=0; M0 AR waits until the response is taken
        ar_q.push_back('{1, 32'h0000_0F00});
        ar_q.push_back('{0, 32'h0000_0100});
        r1_q.push_back(32'hDEAD_B1EF);
        r0_q.push_back(32'hDEAD_BFEF);
        m1_rready = 0;
        m_read(1, 32'h0000_0F00);
        fork
            m_read(0, 32'h0000_0100);
            begin
                wait_rvalid(1);
                repeat (4) begin
                    @(negedge clk);
                    chk("t3_m1_rvalid_held", m1_rvalid, 1);
                    chk("t3_m0_rvalid", m0_rvalid, 0);
                    chk("t3_m0_arready_busy", m0_arready, 0);
                end
                @(posedge clk);
                #1 m1_rready = 1;
            end
        join
        wait_drain();

        // 4: continuous reads from both masters alternate M0,M1,M0 with a bubble
        do_reset(2);
        ar_q.push_back('{0, 32'h0000_0200});
        ar_q.push_back('{1, 32'h0000_0300});
        ar_q.push_back('{0, 32'h0000_0400});
        r0_q.push_back(32'hDEAD_BCEF);
        r1_q.push_back(32'hDEAD_BDEF);
        r0_q.push_back(32'hDEAD_BAEF);
        chk_gap = 1;
        fork
            begin
                m_read(0, 32'h0000_0200);
                m_read(0, 32'h0000_0400);
            end
            m_read(1, 32'h0000_0300);
        join
        wait_drain();
        chk_gap = 0;

        // 5: M0 write proceeds while M1's read is outstanding
        ar_q.push_back('{1, 32'h0000_0800});
        r1_q.push_back(32'hDEAD_B6EF);
        w_q.push_back('{0, 32'h0000_0404, 32'h1234_5678, 4'h3});
        m1_rready = 0;
        m_read(1, 32'h0000_0800);
        wait_rvalid(1);
        @(posedge clk);
        #1;
        t0 = cyc;
        m_write(0, 32'h0000_0404, 32'h1234_5678, 4'h3);
        chk("t5_wr_latency", cyc - t0, 1);
        @(negedge clk);
        chk("t5_rvalid_kept", m1_rvalid, 1);
        @(posedge clk);
        #1 m1_rready = 1;
        wait_drain();

        // 6: reset in R_BUSY drops the pending response; a fresh M0 read works
        ar_q.push_back('{1, 32'h0000_0F00});
        m1_rready = 0;
        m_read(1, 32'h0000_0F00);
        wait_rvalid(1);
        do_reset(1);
        @(negedge clk);
        chk("t6_outs_zero", outs_main(), 0);
        m1_rready = 1;
        ar_q.push_back('{0, 32'h0000_0500});
        r0_q.push_back(32'hDEAD_BBEF);
        @(posedge clk);
        #1;
        m_read(0, 32'h0000_0500);
        wait_drain();

        // 7: the fixed-priority instance saw ties on both channels
        chk("t7_fix_wr_ties", fix_w_n >= 5, 1);
        chk("t7_fix_rd_ties", fix_r_n >= 2, 1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
